// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART timing constants and the receiver state encoding. tx_uart and
// uart_rx both import this package, so both ends of a loopback agree on
// the bit period.
//   FREQ : system clock frequency in Hz
//   BAUD : line bit rate
//   CLKS : clocks per bit (FREQ/BAUD = 234)
//   HALF : clocks from the start-bit edge to the mid-bit sample (117)
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int FREQ = 27_000_000;
   localparam int BAUD = 115_200;
   localparam int CLKS = FREQ / BAUD;
   localparam int HALF = CLKS / 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   // Truncate an integer clock count to the width of the bit-period counter.
   function automatic logic [7:0] cnt8(input int value);
      return value[7:0];
   endfunction

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer for asynchronous inputs, one independent chain per
// bit. The flops reset to RST_VAL, so an idle-high serial line never shows a
// false start bit coming out of reset.
// Ports:
//   clk : destination clock
//   rst : synchronous, active-high reset
//   d   : asynchronous input(s)
//   q   : synchronized output(s), two clocks behind d
// -----------------------------------------------------------------------------
module uart_sync #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk) begin
         if (rst) begin
            meta_reg <= RST_VAL[gi];
            sync_reg <= RST_VAL[gi];
         end else begin
            meta_reg <= d[gi];
            sync_reg <= meta_reg;
         end
      end

      assign q[gi] = sync_reg;
   end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver for 8N1 frames (LSB first) with a one-entry valid/ready
// holding register. The stop bit (and the parity bit when enabled) is
// sampled mid-bit; the byte is delivered on the same edge that samples a
// good stop bit.
// Build option: define UART_RX_PARITY_EN for 8E1 frames (even parity),
// which adds the PARITY state and the parity_err output.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous, active-high reset
//   rx         : asynchronous serial line, idle high
//   data       : received byte
//   valid      : data holds an unread byte
//   ready      : consumer accepts data when valid && ready
//   frame_err  : one-cycle pulse, stop bit sampled 0
//   overrun    : one-cycle pulse, completed byte dropped (register full)
//   parity_err : one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam logic [7:0] CNT_HALF = cnt8(HALF - 1);
   localparam logic [7:0] CNT_LAST = cnt8(CLKS - 1);

   logic rxs;

   rx_state_t  state_reg,   state_next;
   logic [7:0] clk_cnt_reg, clk_cnt_next;
   logic [3:0] bit_cnt_reg, bit_cnt_next;
   logic [7:0] shreg_reg,   shreg_next;

   logic stop_good;
   logic stop_bad;
   logic deliver;

   logic [7:0] data_reg;
   logic       valid_reg;
   logic       frame_err_reg;
   logic       overrun_reg;

`ifdef UART_RX_PARITY_EN
   logic par_bad_reg, par_bad_next;
   logic parity_err_reg;
`endif

   uart_sync #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rxs)
   );

   // -------------------------------------------------------------------------
   // Frame FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         clk_cnt_reg <= '0;
         bit_cnt_reg <= '0;
         shreg_reg   <= '0;
`ifdef UART_RX_PARITY_EN
         par_bad_reg <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         clk_cnt_reg <= clk_cnt_next;
         bit_cnt_reg <= bit_cnt_next;
         shreg_reg   <= shreg_next;
`ifdef UART_RX_PARITY_EN
         par_bad_reg <= par_bad_next;
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Frame FSM: next state. clk_cnt restarts from 0 at every state change and
   // at every bit boundary inside DATA.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      clk_cnt_next = clk_cnt_reg + 8'd1;
      bit_cnt_next = bit_cnt_reg;
      shreg_next   = shreg_reg;
      stop_good    = 1'b0;
      stop_bad     = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_next = par_bad_reg;
`endif

      case (state_reg)
         IDLE: begin
            clk_cnt_next = '0;
            bit_cnt_next = '0;
            if (!rxs) begin
               state_next = START;
            end
         end

         START: begin
            // Re-check the line mid start bit so short glitches are ignored.
            if (clk_cnt_reg == CNT_HALF) begin
               clk_cnt_next = '0;
               state_next   = rxs ? IDLE : DATA;
            end
         end

         DATA: begin
            if (clk_cnt_reg == CNT_LAST) begin
               clk_cnt_next = '0;
               shreg_next   = {rxs, shreg_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 4'd1;
               if (bit_cnt_reg == 4'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (clk_cnt_reg == CNT_LAST) begin
               clk_cnt_next = '0;
               par_bad_next = ^{rxs, shreg_reg};
               state_next   = STOP;
            end
         end
`endif

         STOP: begin
            if (clk_cnt_reg == CNT_LAST) begin
               clk_cnt_next = '0;
               if (rxs) begin
                  stop_good  = 1'b1;
                  state_next = IDLE;
               end else begin
                  stop_bad   = 1'b1;
                  state_next = BREAK;
               end
            end
         end

         BREAK: begin
            // A line held low after a bad stop bit must not look like a
            // fresh start bit; wait for it to return high first.
            clk_cnt_next = '0;
            if (rxs) begin
               state_next = IDLE;
            end
         end

         default: begin
            clk_cnt_next = '0;
            state_next   = IDLE;
         end
      endcase
   end

`ifdef UART_RX_PARITY_EN
   assign deliver = stop_good && !par_bad_reg;
`else
   assign deliver = stop_good;
`endif

   // -------------------------------------------------------------------------
   // Holding register and status pulses. A delivery coinciding with a
   // handshake replaces the old byte without dropping valid.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         data_reg       <= '0;
         valid_reg      <= 1'b0;
         frame_err_reg  <= 1'b0;
         overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_reg <= 1'b0;
`endif
      end else begin
         frame_err_reg  <= stop_bad;
         overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_reg <= stop_good && par_bad_reg;
`endif
         if (deliver) begin
            if (!valid_reg || ready) begin
               data_reg  <= shreg_reg;
               valid_reg <= 1'b1;
            end else begin
               overrun_reg <= 1'b1;
            end
         end else if (valid_reg && ready) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign data      = data_reg;
   assign valid     = valid_reg;
   assign frame_err = frame_err_reg;
   assign overrun   = overrun_reg;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed and randomized frames driven onto rx at CLKS clocks per bit. A
// negedge monitor collects every accepted byte and counts status pulses;
// the expected-byte queue and expected pulse counts come from the frame
// contents and the valid/ready rules.
// -----------------------------------------------------------------------------
module tb_uart_rx;
   import uart_pkg::*;

`ifdef UART_RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   // Edges from the rx falling edge to valid: sync + half bit + rest of frame + register.
   localparam int DLAT = 2 + HALF + (NB - 1) * CLKS + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   uart_rx dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- monitor ----------------
   logic [7:0] acc_q[$];
   logic [7:0] exp_q[$];
   int  fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vhi_cnt = 0, rise_cyc = 0;
   logic valid_d = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         if (valid && ready) acc_q.push_back(data);
         if (valid) vhi_cnt++;
         if (valid && !valid_d) rise_cyc = cyc;
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
         if (parity_err) pe_cnt++;
`endif
      end
      valid_d = valid;
   end

   // ---------------- checking ----------------
   int n_pass = 0, n_fail = 0, n_total = 0;
   int t_start = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_acc(input string tag);
      check({tag, "_count"}, acc_q.size(), exp_q.size());
      if (acc_q.size() == exp_q.size())
         for (int i = 0; i < acc_q.size(); i++) check(tag, acc_q[i], exp_q[i]);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one frame for ncyc clocks; optionally raise ready for exactly the
   // delivery edge of this frame.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par,
                             input bit pulse_rdy, input int ncyc);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      if (NB == 11) bits.push_back((^b) ^ bad_par);
      bits.push_back(stop_bit);
      @(posedge clk);
      #1;
      rx = bits[0];
      t_start = cyc;
      for (int c = 1; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         rx = bits[c / CLKS];
         if (pulse_rdy && c == DLAT - 1) ready = 1'b1;
         if (pulse_rdy && c == DLAT) ready = 1'b0;
      end
      if (ncyc == NB * CLKS) idle(1);
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b1, 1'b0, 1'b0, NB * CLKS);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      int vsnap;
      logic [7:0] rb;

      rst = 1'b1; rx = 1'b1; ready = 1'b0;
      idle(4);
      check("rst_data", data, 8'h00);
      check("rst_valid", valid, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_overrun", overrun, 1'b0);
`ifdef UART_RX_PARITY_EN
      check("rst_parity_err", parity_err, 1'b0);
`endif
      rst = 1'b0;
      idle(5);

      // T1: 0x41 with ready high, single-cycle valid, latency window
      ready = 1'b1;
      send(8'h41);
      idle(20);
      exp_q.push_back(8'h41);
      check_acc("t1_data");
      lat = rise_cyc - t_start;
      n_total++;
      assert (lat >= DLAT - 1 && lat <= DLAT + 1) n_pass++;
      else begin
         n_fail++;
         $error("FAIL t1_latency: got %0d expected %0d+-1", lat, DLAT);
      end
      check("t1_valid_cycles", vhi_cnt, 1);
      check("t1_frame_err", fe_cnt, 0);

      // T2: 50-cycle glitch, then a clean 0xA5
      rx = 1'b0;
      idle(50);
      rx = 1'b1;
      idle(400);
      check("t2_glitch_no_valid", vhi_cnt, 1);
      send(8'hA5);
      idle(20);
      exp_q.push_back(8'hA5);
      check_acc("t2_data");

      // T3: bad stop bit, line held low, then 0x3C
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, NB * CLKS);
      idle(1000);
      rx = 1'b1;
      idle(20);
      check("t3_frame_err_pulses", fe_cnt, 1);
      send(8'h3C);
      idle(20);
      exp_q.push_back(8'h3C);
      check_acc("t3_data");
      check("t3_frame_err_after", fe_cnt, 1);

      // T4: overrun while holding 0x11
      ready = 1'b0;
      send(8'h11);
      idle(20);
      send(8'h22);
      idle(20);
      check("t4_held_data", data, 8'h11);
      check("t4_held_valid", valid, 1'b1);
      check("t4_overrun_pulses", ov_cnt, 1);
      ready = 1'b1;
      idle(3);
      exp_q.push_back(8'h11);
      check("t4_valid_cleared", valid, 1'b0);
      check_acc("t4_data");

      // T5: handshake on the exact delivery edge replaces the byte
      ready = 1'b0;
      send(8'h11);
      idle(20);
      send_frame(8'h22, 1'b1, 1'b0, 1'b1, NB * CLKS);
      idle(5);
      exp_q.push_back(8'h11);
      check("t5_no_overrun", ov_cnt, 1);
      check("t5_data", data, 8'h22);
      check("t5_valid", valid, 1'b1);
      ready = 1'b1;
      idle(3);
      exp_q.push_back(8'h22);
      check_acc("t5_accepted");
      check("t5_valid_cleared", valid, 1'b0);

      // T6: reset during data bit 4 while a byte is held
      ready = 1'b0;
      send(8'h5A);
      idle(20);
      check("t6_held_valid", valid, 1'b1);
      send_frame(8'h99, 1'b1, 1'b0, 1'b0, 5 * CLKS + 130);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t6_rst_data", data, 8'h00);
      check("t6_rst_valid", valid, 1'b0);
      check("t6_rst_frame_err", frame_err, 1'b0);
      check("t6_rst_overrun", overrun, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rx = 1'b1;
      idle(10);
      ready = 1'b1;
      send(8'h7E);
      idle(20);
      exp_q.push_back(8'h7E);
      check_acc("t6_data");

      // T7: random bytes and gaps
      for (int k = 0; k < 6; k++) begin
         rb = 8'($urandom_range(0, 255));
         send(rb);
         exp_q.push_back(rb);
         idle($urandom_range(1, 40));
      end
      idle(10);
      check_acc("t7_random");
      check("t7_frame_err", fe_cnt, 1);
      check("t7_overrun", ov_cnt, 1);

`ifdef UART_RX_PARITY_EN
      // T8: 0x41 with wrong parity bit, then with correct parity
      vsnap = vhi_cnt;
      send_frame(8'h41, 1'b1, 1'b1, 1'b0, NB * CLKS);
      idle(20);
      check("t8_parity_err_pulses", pe_cnt, 1);
      check("t8_no_valid", vhi_cnt - vsnap, 0);
      check_acc("t8_dropped");
      send(8'h41);
      idle(20);
      exp_q.push_back(8'h41);
      check_acc("t8_good");
      check("t8_parity_err_after", pe_cnt, 1);
`else
      vsnap = vhi_cnt;
      check("t8_idle_valid", vsnap - vhi_cnt, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
